// File: rtl/recv_ip_frame.sv
// IPv4 receive parser: validates Ethernet/IPv4 headers from the MAC RX word stream,
// publishes header fields and forwards the IP payload as a sop/eop stream.
//
// state   | meaning
// IDLE    | waiting for sop, captures W0
// HDR     | collecting header words W1..W8
// CHECK   | one-cycle header verdict, eth input stalled
// PAYLOAD | zero-latency pass-through of payload words
// DRAIN   | discard padding / rejected frame until eop
module recv_ip_frame #(
    parameter bit CHECK_DST_MAC = 1'b1,
    parameter bit CHECK_DST_IP  = 1'b1,
    parameter bit ACCEPT_BCAST  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] i_local_mac,
    input  logic [31:0] i_local_ip,
    input  logic [31:0] i_eth_data,
    input  logic        i_eth_sop,
    input  logic        i_eth_eop,
    input  logic        i_eth_vld,
    output logic        o_eth_rdy,
    output logic        o_hdr_vld,
    output logic [47:0] o_src_mac,
    output logic [31:0] o_src_ip,
    output logic [31:0] o_dst_ip,
    output logic [7:0]  o_protocol,
    output logic [15:0] o_pkt_id,
    output logic        o_more_frame,
    output logic [15:0] o_frame_offset,
    output logic [15:0] o_frame_size,
    output logic [31:0] o_out_data,
    output logic        o_out_sop,
    output logic        o_out_eop,
    output logic        o_out_vld,
    input  logic        i_out_rdy,
    output logic        o_frame_err,
    output logic [15:0] o_ok_cnt,
    output logic [15:0] o_drop_cnt
);
    typedef enum logic [2:0] {IDLE, HDR, CHECK, PAYLOAD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [13:0] rem_q, rem_d;
    logic        first_q, first_d;
    logic        eop8_q, eop8_d;
    logic [31:0] hdr_q [0:8];
    logic        hdr_wr;
    logic [3:0]  hdr_wr_idx;
    logic        ok_inc, drop_inc;
    logic [15:0] ok_cnt_q, drop_cnt_q;

    logic [47:0] src_mac_q;
    logic [31:0] src_ip_q, dst_ip_q;
    logic [7:0]  protocol_q;
    logic [15:0] pkt_id_q, frame_offset_q, frame_size_q;
    logic        more_frame_q;

    logic [47:0] dmac, smac;
    logic [15:0] tot_len, frame_size, pay_words, cur_offset;
    logic [19:0] csum_sum;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic        mac_ok, ip_ok, hdr_pass;

    assign dmac       = {hdr_q[0][15:0], hdr_q[1]};
    assign smac       = {hdr_q[2], hdr_q[3][31:16]};
    assign tot_len    = hdr_q[4][15:0];
    assign frame_size = tot_len - 16'd20;
    assign pay_words  = (frame_size + 16'd3) >> 2;
    assign cur_offset = {hdr_q[5][12:0], 3'b000};

    // Ones-complement header sum; a correct header sums to all ones.
    assign csum_sum = {4'h0, hdr_q[4][31:16]} + {4'h0, hdr_q[4][15:0]}
                    + {4'h0, hdr_q[5][31:16]} + {4'h0, hdr_q[5][15:0]}
                    + {4'h0, hdr_q[6][31:16]} + {4'h0, hdr_q[6][15:0]}
                    + {4'h0, hdr_q[7][31:16]} + {4'h0, hdr_q[7][15:0]}
                    + {4'h0, hdr_q[8][31:16]} + {4'h0, hdr_q[8][15:0]};
    assign fold1 = {1'b0, csum_sum[15:0]} + {13'h0, csum_sum[19:16]};
    assign fold2 = fold1[15:0] + {15'h0, fold1[16]};

    assign mac_ok = !CHECK_DST_MAC || (dmac == i_local_mac)
                    || (ACCEPT_BCAST && (dmac == 48'hFFFF_FFFF_FFFF));
    assign ip_ok  = !CHECK_DST_IP || (hdr_q[8] == i_local_ip);
    assign hdr_pass = (hdr_q[3][15:0] == 16'h0800) && (hdr_q[4][31:24] == 8'h45)
                    && (tot_len >= 16'd20) && (fold2 == 16'hFFFF) && mac_ok && ip_ok;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        first_d     = first_q;
        eop8_d      = eop8_q;
        hdr_wr      = 1'b0;
        hdr_wr_idx  = idx_q;
        ok_inc      = 1'b0;
        drop_inc    = 1'b0;
        o_eth_rdy   = 1'b0;
        o_out_vld   = 1'b0;
        o_out_sop   = 1'b0;
        o_out_eop   = 1'b0;
        o_hdr_vld   = 1'b0;
        o_frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                o_eth_rdy = 1'b1;
                if (i_eth_vld && i_eth_sop) begin
                    hdr_wr     = 1'b1;
                    hdr_wr_idx = 4'd0;
                    if (i_eth_eop) begin
                        o_frame_err = 1'b1;
                        drop_inc    = 1'b1;
                    end else begin
                        idx_d   = 4'd1;
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                o_eth_rdy = 1'b1;
                if (i_eth_vld) begin
                    hdr_wr = 1'b1;
                    if (i_eth_sop) begin
                        o_frame_err = 1'b1;
                        drop_inc    = 1'b1;
                        hdr_wr_idx  = 4'd0;
                        idx_d       = 4'd1;
                        if (i_eth_eop) state_d = IDLE;
                    end else if (idx_q == 4'd8) begin
                        eop8_d  = i_eth_eop;
                        state_d = CHECK;
                    end else if (i_eth_eop) begin
                        o_frame_err = 1'b1;
                        drop_inc    = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            CHECK: begin
                if (hdr_pass) begin
                    o_hdr_vld = 1'b1;
                    ok_inc    = 1'b1;
                    rem_d     = pay_words[13:0];
                    first_d   = 1'b1;
                    if (eop8_q)                  state_d = IDLE;
                    else if (frame_size == 16'd0) state_d = DRAIN;
                    else                          state_d = PAYLOAD;
                end else begin
                    o_frame_err = 1'b1;
                    drop_inc    = 1'b1;
                    state_d     = eop8_q ? IDLE : DRAIN;
                end
            end
            PAYLOAD: begin
                o_eth_rdy = i_out_rdy;
                if (i_eth_vld && i_eth_sop) begin
                    // Frame already counted as accepted; only flag the abort.
                    if (i_out_rdy) begin
                        o_frame_err = 1'b1;
                        hdr_wr      = 1'b1;
                        hdr_wr_idx  = 4'd0;
                        idx_d       = 4'd1;
                        state_d     = i_eth_eop ? IDLE : HDR;
                    end
                end else begin
                    o_out_vld = i_eth_vld;
                    o_out_sop = i_eth_vld && first_q;
                    o_out_eop = i_eth_vld && ((rem_q == 14'd1) || i_eth_eop);
                    if (i_eth_vld && i_out_rdy) begin
                        first_d = 1'b0;
                        rem_d   = rem_q - 14'd1;
                        if (i_eth_eop) begin
                            state_d     = IDLE;
                            o_frame_err = (rem_q != 14'd1);
                        end else if (rem_q == 14'd1) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                o_eth_rdy = 1'b1;
                if (i_eth_vld) begin
                    if (i_eth_sop) begin
                        o_frame_err = 1'b1;
                        hdr_wr      = 1'b1;
                        hdr_wr_idx  = 4'd0;
                        idx_d       = 4'd1;
                        state_d     = i_eth_eop ? IDLE : HDR;
                    end else if (i_eth_eop) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) o_eth_rdy = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) hdr_q[i] <= '0;
        end else if (hdr_wr) begin
            hdr_q[hdr_wr_idx] <= i_eth_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            rem_q          <= '0;
            first_q        <= 1'b0;
            eop8_q         <= 1'b0;
            ok_cnt_q       <= '0;
            drop_cnt_q     <= '0;
            src_mac_q      <= '0;
            src_ip_q       <= '0;
            dst_ip_q       <= '0;
            protocol_q     <= '0;
            pkt_id_q       <= '0;
            more_frame_q   <= 1'b0;
            frame_offset_q <= '0;
            frame_size_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            eop8_q  <= eop8_d;
            if (ok_inc)   ok_cnt_q   <= ok_cnt_q + 16'd1;
            if (drop_inc) drop_cnt_q <= drop_cnt_q + 16'd1;
            if (ok_inc) begin
                src_mac_q      <= smac;
                src_ip_q       <= hdr_q[7];
                dst_ip_q       <= hdr_q[8];
                protocol_q     <= hdr_q[6][23:16];
                pkt_id_q       <= hdr_q[5][31:16];
                more_frame_q   <= hdr_q[5][13];
                frame_offset_q <= cur_offset;
                frame_size_q   <= frame_size;
            end
        end
    end

    // Fields are shown live during the accept pulse, then held from the latch.
    assign o_src_mac      = o_hdr_vld ? smac            : src_mac_q;
    assign o_src_ip       = o_hdr_vld ? hdr_q[7]        : src_ip_q;
    assign o_dst_ip       = o_hdr_vld ? hdr_q[8]        : dst_ip_q;
    assign o_protocol     = o_hdr_vld ? hdr_q[6][23:16] : protocol_q;
    assign o_pkt_id       = o_hdr_vld ? hdr_q[5][31:16] : pkt_id_q;
    assign o_more_frame   = o_hdr_vld ? hdr_q[5][13]    : more_frame_q;
    assign o_frame_offset = o_hdr_vld ? cur_offset      : frame_offset_q;
    assign o_frame_size   = o_hdr_vld ? frame_size      : frame_size_q;
    assign o_out_data     = o_out_vld ? i_eth_data      : '0;
    assign o_ok_cnt       = ok_cnt_q;
    assign o_drop_cnt     = drop_cnt_q;
endmodule
